seq_detector: RTL

- Serial bit-stream pattern detector with a runtime-programmable pattern (1..MAX_LEN bits), selectable overlapping or non-overlapping match mode, an input-valid qualifier and a saturating match counter.
- Parametrised successor to the fixed 5-bit "10110" detector.
- Sits on serial framing/sync paths; found pulses feed downstream framers, and match_count is read by status logic.

---
 rtl/seq_detector.sv | 122 ++++++++++++
 1 files changed

// File: rtl/seq_detector.sv
// Serial pattern detector: programmable 1..MAX_LEN-bit pattern, with overlapping and non-overlapping modes and a saturating match counter.
// found is registered one cycle after the matching bit; there is no backpressure, and bits are taken whenever bit_valid is high.
module seq_detector #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               bit_valid,
  input  logic               bit_in,
  input  logic               clr_count,
  output logic               found,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);

  typedef enum logic [1:0] {S_DISABLED, S_FILL, S_ARMED} state_t;

  localparam logic [MAX_LEN-1:0] DEF_PAT   = MAX_LEN'(5'b10110);
  localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   DEF_LEN   = (MAX_LEN < 5) ? MAX_LEN_L : LEN_W'(5);
  localparam logic [MAX_LEN:0]   ONE_EXT   = (MAX_LEN + 1)'(1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  state_t               r_state, w_state_nxt;
  logic [MAX_LEN-1:0]   r_pat, r_hist, w_hist_nxt, w_hist_shift, w_mask;
  logic [LEN_W-1:0]     r_len, r_fill, w_fill_nxt, w_len_clamp;
  logic                 r_ovl, r_found, r_sat, w_sat_nxt, w_sat_base, w_match;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt, w_cnt_base, w_cnt_inc;
  logic [MAX_LEN:0]     w_mask_ext;
  logic [LEN_W:0]       w_fill_inc;

  assign w_len_clamp  = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
  assign w_hist_shift = {r_hist[MAX_LEN-2:0], bit_in};
  // Mask built one bit wider so len == MAX_LEN yields all ones without overflow.
  assign w_mask_ext   = (ONE_EXT << r_len) - ONE_EXT;
  assign w_mask       = w_mask_ext[MAX_LEN-1:0];
  assign w_fill_inc   = {1'b0, r_fill} + (LEN_W + 1)'(1);

  assign w_match = bit_valid && !cfg_load && (r_state != S_DISABLED) &&
                   (((w_hist_shift ^ r_pat) & w_mask) == '0) &&
                   (w_fill_inc >= {1'b0, r_len});

  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill;
    w_hist_nxt  = r_hist;
    if (cfg_load) begin
      w_hist_nxt  = '0;
      w_fill_nxt  = '0;
      w_state_nxt = (w_len_clamp == '0) ? S_DISABLED : S_FILL;
    end else if (bit_valid) begin
      w_hist_nxt = w_hist_shift;
      case (r_state)
        S_FILL: begin
          if (w_match && !r_ovl) begin
            w_fill_nxt = '0;
          end else begin
            w_fill_nxt = w_fill_inc[LEN_W-1:0];
            if (w_fill_inc == {1'b0, r_len}) w_state_nxt = S_ARMED;
          end
        end
        S_ARMED: begin
          if (w_match && !r_ovl) begin
            w_fill_nxt  = '0;
            w_state_nxt = S_FILL;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Clear happens before count so a coincident match lands at 1.
  always_comb begin
    w_cnt_base = clr_count ? '0 : r_cnt;
    w_sat_base = clr_count ? 1'b0 : r_sat;
    w_cnt_inc  = w_cnt_base + CNT_W'(1);
    w_cnt_nxt  = w_cnt_base;
    w_sat_nxt  = w_sat_base;
    if (w_match && (w_cnt_base != CNT_MAX)) begin
      w_cnt_nxt = w_cnt_inc;
      w_sat_nxt = w_sat_base || (w_cnt_inc == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FILL;
      r_pat   <= DEF_PAT;
      r_len   <= DEF_LEN;
      r_ovl   <= 1'b1;
      r_hist  <= '0;
      r_fill  <= '0;
      r_found <= 1'b0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hist  <= w_hist_nxt;
      r_fill  <= w_fill_nxt;
      r_found <= w_match;
      r_cnt   <= w_cnt_nxt;
      r_sat   <= w_sat_nxt;
      if (cfg_load) begin
        r_pat <= cfg_pattern;
        r_len <= w_len_clamp;
        r_ovl <= cfg_overlap;
      end
    end
  end

  assign found       = r_found;
  assign match_count = r_cnt;
  assign count_sat   = r_sat;

endmodule
